// File: rtl/transpose_pingpong.sv
// N x N matrix transposer: rows in, columns out, two ping-pong banks so one
// matrix loads while the other drains. Short matrices (in_last) are zero-filled.
module transpose_pingpong #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8,
  parameter int unsigned LOGN  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 out_last,
  output logic [1:0]           occupancy,
  output logic                 busy
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  logic [1:0]      bst_q [2];
  logic [1:0]      bst_d [2];
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [LOGN-1:0] wrow_q, wrow_d;
  logic [LOGN-1:0] rcol_q, rcol_d;

  // Storage is column-major per bank: mem[bank][col][row].
  logic [WIDTH-1:0] mem [2][N][N];

  logic in_fire, out_fire, wr_done, rd_done;

  // Handshakes and status decoded purely from registered state.
  always_comb begin
    in_ready  = (bst_q[wbank_q] != ST_FULL);
    out_valid = (bst_q[rbank_q] == ST_FULL);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    wr_done   = in_fire & (in_last | (wrow_q == LAST_IDX));
    rd_done   = out_fire & (rcol_q == LAST_IDX);
    out_last  = out_valid & (rcol_q == LAST_IDX);
    occupancy = 2'(bst_q[0] == ST_FULL) + 2'(bst_q[1] == ST_FULL);
    busy      = (bst_q[0] != ST_EMPTY) | (bst_q[1] != ST_EMPTY);
  end

  always_comb begin
    out_data = '0;
    for (int unsigned r = 0; r < N; r++) begin
      out_data[r*WIDTH +: WIDTH] = mem[rbank_q][rcol_q][r];
    end
  end

  // Bank state and pointer next-state; fill and drain always hit different banks.
  always_comb begin
    bst_d   = bst_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wrow_d  = wrow_q;
    rcol_d  = rcol_q;
    if (in_fire) begin
      bst_d[wbank_q] = wr_done ? ST_FULL : ST_FILLING;
      wrow_d         = wr_done ? '0 : wrow_q + LOGN'(1);
      if (wr_done) begin
        wbank_d = ~wbank_q;
      end
    end
    if (out_fire) begin
      rcol_d = rd_done ? '0 : rcol_q + LOGN'(1);
      if (rd_done) begin
        bst_d[rbank_q] = ST_EMPTY;
        rbank_d        = ~rbank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bst_q[0] <= ST_EMPTY;
      bst_q[1] <= ST_EMPTY;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      wrow_q   <= '0;
      rcol_q   <= '0;
    end else begin
      bst_q    <= bst_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      wrow_q   <= wrow_d;
      rcol_q   <= rcol_d;
    end
  end

  // Drained banks are cleared so unwritten rows of a short matrix read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < N; c++) begin
          for (int unsigned r = 0; r < N; r++) begin
            mem[b][c][r] <= '0;
          end
        end
      end
    end else begin
      if (in_fire) begin
        for (int unsigned c = 0; c < N; c++) begin
          mem[wbank_q][c][wrow_q] <= in_data[c*WIDTH +: WIDTH];
        end
      end
      if (rd_done) begin
        for (int unsigned c = 0; c < N; c++) begin
          for (int unsigned r = 0; r < N; r++) begin
            mem[rbank_q][c][r] <= '0;
          end
        end
      end
    end
  end

endmodule
